// File: rtl/frame_buffer_page_scheduler.sv
// Triple-buffer page scheduler: rotates three frame pages between the camera
// writer, the HDMI reader and a "ready" slot, and drives per-path base addresses.
module frame_buffer_page_scheduler #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  enable_i,
  input  logic [15:0]           resolution_width_i,
  input  logic [15:0]           resolution_depth_i,
  input  logic                  wr_frame_done_i,
  input  logic                  rd_frame_start_i,
  output logic [1:0]            wr_page_o,
  output logic [1:0]            rd_page_o,
  output logic [ADDR_WIDTH-1:0] wr_base_addr_o,
  output logic [ADDR_WIDTH-1:0] rd_base_addr_o,
  output logic                  rd_valid_o,
  output logic [CNT_WIDTH-1:0]  drop_cnt_o,
  output logic [CNT_WIDTH-1:0]  repeat_cnt_o
);

  typedef enum logic [1:0] {IDLE, LATCH, FILL, RUN} state_t;

  state_t                state, state_next;
  logic [1:0]            rdy_page;
  logic                  rdy_valid;
  logic [ADDR_WIDTH-1:0] base1, base2;

  logic [1:0]            wr_page_next, rd_page_next, rdy_page_next;
  logic                  rdy_valid_next, rd_valid_next;
  logic                  drop_inc, repeat_inc;
  logic [ADDR_WIDTH-1:0] base1_next, base2_next;
  logic [ADDR_WIDTH-1:0] wr_base_next, rd_base_next;

  logic [31:0]            pixel_product;
  logic [ADDR_WIDTH+31:0] product_wide;
  logic [ADDR_WIDTH-1:0]  frame_size;

  // Zero-extend before truncating so any ADDR_WIDTH (above or below 32) works.
  assign pixel_product = {16'd0, resolution_width_i} * {16'd0, resolution_depth_i};
  assign product_wide  = {{ADDR_WIDTH{1'b0}}, pixel_product};
  assign frame_size    = product_wide[ADDR_WIDTH-1:0];

  function automatic logic [ADDR_WIDTH-1:0] page_base(
    input logic [1:0]            page,
    input logic [ADDR_WIDTH-1:0] b1,
    input logic [ADDR_WIDTH-1:0] b2
  );
    case (page)
      2'd1:    page_base = b1;
      2'd2:    page_base = b2;
      default: page_base = '0;
    endcase
  endfunction

  always_comb begin
    state_next     = state;
    wr_page_next   = wr_page_o;
    rd_page_next   = rd_page_o;
    rdy_page_next  = rdy_page;
    rdy_valid_next = rdy_valid;
    rd_valid_next  = rd_valid_o;
    drop_inc       = 1'b0;
    repeat_inc     = 1'b0;
    base1_next     = base1;
    base2_next     = base2;

    unique case (state)
      IDLE: begin
        state_next = LATCH;
      end
      LATCH: begin
        base1_next = frame_size;
        base2_next = {frame_size[ADDR_WIDTH-2:0], 1'b0};
        state_next = FILL;
      end
      FILL: begin
        if (wr_frame_done_i) begin
          wr_page_next   = rdy_page;
          rdy_page_next  = wr_page_o;
          rdy_valid_next = 1'b1;
          state_next     = RUN;
        end
      end
      RUN: begin
        unique case ({wr_frame_done_i, rd_frame_start_i})
          2'b10: begin
            wr_page_next   = rdy_page;
            rdy_page_next  = wr_page_o;
            drop_inc       = rdy_valid;
            rdy_valid_next = 1'b1;
          end
          2'b01: begin
            if (rdy_valid) begin
              rd_page_next   = rdy_page;
              rdy_page_next  = rd_page_o;
              rdy_valid_next = 1'b0;
              rd_valid_next  = 1'b1;
            end else begin
              repeat_inc = 1'b1;
            end
          end
          2'b11: begin
            // The frame just finished goes straight to the reader.
            wr_page_next   = rdy_page;
            rd_page_next   = wr_page_o;
            rdy_page_next  = rd_page_o;
            rdy_valid_next = 1'b0;
            rd_valid_next  = 1'b1;
            drop_inc       = rdy_valid;
          end
          default: ;
        endcase
      end
      default: state_next = IDLE;
    endcase

    if (!enable_i || state == IDLE) begin
      wr_page_next   = 2'd0;
      rdy_page_next  = 2'd1;
      rd_page_next   = 2'd2;
      rdy_valid_next = 1'b0;
      rd_valid_next  = 1'b0;
      drop_inc       = 1'b0;
      repeat_inc     = 1'b0;
    end
    if (!enable_i) begin
      state_next = IDLE;
    end

    if (state_next == FILL || state_next == RUN) begin
      wr_base_next = page_base(wr_page_next, base1_next, base2_next);
      rd_base_next = page_base(rd_page_next, base1_next, base2_next);
    end else begin
      wr_base_next = '0;
      rd_base_next = '0;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state          <= IDLE;
      wr_page_o      <= 2'd0;
      rd_page_o      <= 2'd2;
      rdy_page       <= 2'd1;
      rdy_valid      <= 1'b0;
      rd_valid_o     <= 1'b0;
      base1          <= '0;
      base2          <= '0;
      wr_base_addr_o <= '0;
      rd_base_addr_o <= '0;
      drop_cnt_o     <= '0;
      repeat_cnt_o   <= '0;
    end else begin
      state          <= state_next;
      wr_page_o      <= wr_page_next;
      rd_page_o      <= rd_page_next;
      rdy_page       <= rdy_page_next;
      rdy_valid      <= rdy_valid_next;
      rd_valid_o     <= rd_valid_next;
      base1          <= base1_next;
      base2          <= base2_next;
      wr_base_addr_o <= wr_base_next;
      rd_base_addr_o <= rd_base_next;
      if (drop_inc && drop_cnt_o != {CNT_WIDTH{1'b1}}) begin
        drop_cnt_o <= drop_cnt_o + 1'b1;
      end
      if (repeat_inc && repeat_cnt_o != {CNT_WIDTH{1'b1}}) begin
        repeat_cnt_o <= repeat_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_buffer_page_scheduler.sv
// Directed bench for frame_buffer_page_scheduler: a per-cycle vector table plus
// hand sequences for counter saturation, disable, re-latch and async reset.
module tb_frame_buffer_page_scheduler;

  localparam int AW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetn, enable, wr_done, rd_start;
  logic [15:0]   width, depth;
  logic [1:0]    wr_page, rd_page;
  logic [AW-1:0] wr_base, rd_base;
  logic          rd_valid;
  logic [CW-1:0] drop_cnt, repeat_cnt;

  frame_buffer_page_scheduler #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk_i              (clk),
    .resetn_i           (resetn),
    .enable_i           (enable),
    .resolution_width_i (width),
    .resolution_depth_i (depth),
    .wr_frame_done_i    (wr_done),
    .rd_frame_start_i   (rd_start),
    .wr_page_o          (wr_page),
    .rd_page_o          (rd_page),
    .wr_base_addr_o     (wr_base),
    .rd_base_addr_o     (rd_base),
    .rd_valid_o         (rd_valid),
    .drop_cnt_o         (drop_cnt),
    .repeat_cnt_o       (repeat_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int wrp, input int rdp, input int wb,
                           input int rb, input int v, input int d, input int r);
    chk({tag, ".wr_page"},  32'(wr_page),    32'(wrp));
    chk({tag, ".rd_page"},  32'(rd_page),    32'(rdp));
    chk({tag, ".wr_base"},  wr_base,         32'(wb));
    chk({tag, ".rd_base"},  rd_base,         32'(rb));
    chk({tag, ".rd_valid"}, 32'(rd_valid),   32'(v));
    chk({tag, ".drop"},     32'(drop_cnt),   32'(d));
    chk({tag, ".repeat"},   32'(repeat_cnt), 32'(r));
    $display("%s: wr=%0d rd=%0d wb=%0d rb=%0d v=%0d drop=%0d rep=%0d",
             tag, wr_page, rd_page, wr_base, rd_base, rd_valid, drop_cnt, repeat_cnt);
  endtask

  // Drive inputs on the falling edge, sample 1 ns after the following rising edge.
  task automatic step(input logic en, input logic wr, input logic rd);
    @(negedge clk);
    enable   = en;
    wr_done  = wr;
    rd_start = rd;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic  en, wr, rd;
    int    wrp, rdp, wb, rb, v, d, r;
    string name;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // Expected outputs after the edge; resolution 4x2 -> bases 0, 8, 16.
    vecs[0]  = '{1, 0, 0, 0, 2,  0,  0, 0, 0, 0, "latch"};
    vecs[1]  = '{1, 0, 0, 0, 2,  0, 16, 0, 0, 0, "fill_entry"};
    vecs[2]  = '{1, 0, 1, 0, 2,  0, 16, 0, 0, 0, "fill_rd_ignored"};
    vecs[3]  = '{1, 1, 0, 1, 2,  8, 16, 0, 0, 0, "first_write"};
    vecs[4]  = '{1, 0, 1, 1, 0,  8,  0, 1, 0, 0, "first_read"};
    vecs[5]  = '{1, 0, 1, 1, 0,  8,  0, 1, 0, 1, "repeat_read"};
    vecs[6]  = '{1, 1, 0, 2, 0, 16,  0, 1, 0, 1, "write_a"};
    vecs[7]  = '{1, 1, 0, 1, 0,  8,  0, 1, 1, 1, "write_drop"};
    vecs[8]  = '{1, 1, 1, 2, 1, 16,  8, 1, 2, 1, "both_rdy1"};
    vecs[9]  = '{1, 1, 1, 0, 2,  0, 16, 1, 2, 1, "both_rdy0"};
    vecs[10] = '{1, 0, 0, 0, 2,  0, 16, 1, 2, 1, "quiet"};

    resetn = 1'b0; enable = 1'b0; wr_done = 1'b0; rd_start = 1'b0;
    width = 16'd4; depth = 16'd2;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 2, 0, 0, 0, 0, 0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].en, vecs[i].wr, vecs[i].rd);
      check_all(vecs[i].name, vecs[i].wrp, vecs[i].rdp, vecs[i].wb, vecs[i].rb,
                vecs[i].v, vecs[i].d, vecs[i].r);
    end

    // Resolution change while running must not move the base table.
    width = 16'd8;
    // Pages wr=0 rdy=1 rd=2, rdy_valid=0: 14 back-to-back writes give 13 drops -> 15.
    for (int k = 0; k < 14; k++) step(1'b1, 1'b1, 1'b0);
    check_all("sat_reach", 0, 2, 0, 16, 1, 15, 1);
    step(1'b1, 1'b1, 1'b0);
    check_all("sat_hold", 1, 2, 8, 16, 1, 15, 1);

    step(1'b0, 1'b0, 1'b0);
    check_all("disable", 0, 2, 0, 0, 0, 15, 1);
    step(1'b0, 1'b1, 1'b1);
    check_all("idle_pulses", 0, 2, 0, 0, 0, 15, 1);

    // Re-enable with width 8: frame_size 16, page 2 base 32.
    step(1'b1, 1'b0, 1'b0);
    check_all("relatch", 0, 2, 0, 0, 0, 15, 1);
    step(1'b1, 1'b0, 1'b0);
    check_all("refill", 0, 2, 0, 32, 0, 15, 1);
    step(1'b1, 1'b1, 1'b0);
    check_all("rerun", 1, 2, 16, 32, 0, 15, 1);
    step(1'b1, 1'b0, 1'b1);
    check_all("reread", 1, 0, 16, 0, 1, 15, 1);

    // Asynchronous reset mid-frame, away from any clock edge.
    #2;
    resetn = 1'b0;
    #1;
    check_all("async_reset", 0, 2, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_all("reset_hold", 0, 2, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
